// File: rtl/decode_pkg.sv
// Shared types and tables for the second decode stage: channel uop layout,
// expanded output layout and format id table.
package decode_pkg;

  localparam int unsigned NUM_FMT_DEF = 6;
  localparam int unsigned ADDR_W_DEF  = 64;
  localparam int unsigned OPC_W_DEF   = 6;

  localparam int unsigned REG_W     = 5;
  localparam int unsigned BITS_W    = 4;
  localparam int unsigned XOP_W     = 10;
  localparam int unsigned IMM_RAW_W = 16;
  localparam int unsigned IMM_WID_W = 5;
  localparam int unsigned IMM_SH_W  = 6;
  localparam int unsigned IMM_W     = 64;
  localparam int unsigned FMT_ID_W  = 5;

  localparam logic [FMT_ID_W-1:0] FMT_D  = 5'd3;
  localparam logic [FMT_ID_W-1:0] FMT_DQ = 5'd4;
  localparam logic [FMT_ID_W-1:0] FMT_DS = 5'd5;
  localparam logic [FMT_ID_W-1:0] FMT_X  = 5'd15;
  localparam logic [FMT_ID_W-1:0] FMT_MD = 5'd9;
  localparam logic [FMT_ID_W-1:0] FMT_XO = 5'd19;

  localparam logic [FMT_ID_W-1:0] FMT_ID [NUM_FMT_DEF] =
    '{FMT_D, FMT_DQ, FMT_DS, FMT_X, FMT_MD, FMT_XO};

  typedef struct packed {
    logic [REG_W-1:0]     rt;
    logic [REG_W-1:0]     ra;
    logic [REG_W-1:0]     rb;
    logic                 rt_en;
    logic                 ra_en;
    logic                 rb_en;
    logic                 imm_en;
    logic [BITS_W-1:0]    bits;
    logic [XOP_W-1:0]     xopcode;
    logic [IMM_RAW_W-1:0] imm_raw;
    logic [IMM_WID_W-1:0] imm_width;
    logic                 imm_signed;
    logic [IMM_SH_W-1:0]  imm_shift;
  } chan_uop_t;

  localparam int unsigned UOP_W = $bits(chan_uop_t);

  // Expanded record; address and opcode are appended below it by the stage.
  typedef struct packed {
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    ra;
    logic [REG_W-1:0]    rb;
    logic                rt_en;
    logic                ra_en;
    logic                rb_en;
    logic                imm_en;
    logic [BITS_W-1:0]   bits;
    logic [XOP_W-1:0]    xopcode;
    logic [IMM_W-1:0]    imm;
    logic [FMT_ID_W-1:0] fmt_id;
  } out_base_t;

  localparam int unsigned OUT_BASE_W = $bits(out_base_t);
  localparam int unsigned OUT_W      = OUT_BASE_W + ADDR_W_DEF + OPC_W_DEF;

  // Channels beyond the default table fall back to their own index.
  function automatic logic [FMT_ID_W-1:0] fmt_id_of(input int unsigned k);
    if (k < NUM_FMT_DEF) return FMT_ID[3'(k)];
    return FMT_ID_W'(k);
  endfunction

  function automatic logic [UOP_W-1:0] pack_uop(
    input logic [REG_W-1:0]     rt,
    input logic [REG_W-1:0]     ra,
    input logic [REG_W-1:0]     rb,
    input logic [3:0]           en,
    input logic [BITS_W-1:0]    bits,
    input logic [XOP_W-1:0]     xopcode,
    input logic [IMM_RAW_W-1:0] imm_raw,
    input logic [IMM_WID_W-1:0] imm_width,
    input logic                 imm_signed,
    input logic [IMM_SH_W-1:0]  imm_shift
  );
    chan_uop_t u;
    u.rt         = rt;
    u.ra         = ra;
    u.rb         = rb;
    u.rt_en      = en[3];
    u.ra_en      = en[2];
    u.rb_en      = en[1];
    u.imm_en     = en[0];
    u.bits       = bits;
    u.xopcode    = xopcode;
    u.imm_raw    = imm_raw;
    u.imm_width  = imm_width;
    u.imm_signed = imm_signed;
    u.imm_shift  = imm_shift;
    return u;
  endfunction

endpackage

// File: rtl/decode_mux_stage_imm_expand.sv
// Combinational immediate expansion: mask to width, sign/zero extend, shift.
module imm_expand
  import decode_pkg::*;
(
  input  logic [IMM_RAW_W-1:0] imm_raw,
  input  logic [IMM_WID_W-1:0] imm_width,
  input  logic                 imm_signed,
  input  logic [IMM_SH_W-1:0]  imm_shift,
  input  logic                 imm_enable,
  output logic [IMM_W-1:0]     imm_c
);

  logic [IMM_WID_W-1:0] eff_w;
  logic [IMM_W-1:0]     mask;
  logic [IMM_W-1:0]     ext;
  logic                 sign;

  always_comb begin
    // Widths above the raw field collapse to the full raw field.
    eff_w = (imm_width > 5'd16) ? 5'd16 : imm_width;
    mask  = (IMM_W'(1) << eff_w) - IMM_W'(1);
    sign  = imm_signed && (eff_w != '0) && imm_raw[4'(eff_w - 5'd1)];
    ext   = (IMM_W'(imm_raw) & mask) | (sign ? ~mask : '0);
    imm_c = imm_enable ? (ext << imm_shift) : '0;
  end

endmodule

// File: rtl/decode_mux_stage.sv
// Priority mux over format-decoder channels into a 2-entry skid buffer.
// Optional multi-hot checker: define DECODE_MUX_MULTIHOT_CHECK_EN.
module decode_mux_stage
  import decode_pkg::*;
#(
  parameter int unsigned NUM_FMT = NUM_FMT_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned OPC_W   = OPC_W_DEF
) (
  input  logic                                  clock_i,
  input  logic                                  reset_i,
  input  logic                                  flush_i,
  input  logic [NUM_FMT-1:0]                    fmtValid_i,
  input  logic [NUM_FMT*UOP_W-1:0]              fmtUop_i,
  input  logic [ADDR_W-1:0]                     instructionAddress_i,
  input  logic [OPC_W-1:0]                      opcode_i,
  output logic                                  inReady_o,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  output logic [OUT_BASE_W+ADDR_W+OPC_W-1:0]    uop_o,
  output logic                                  multiHot_o,
  output logic [7:0]                            multiHotCount_o
);

  localparam int unsigned REC_W = OUT_BASE_W + ADDR_W + OPC_W;

  chan_uop_t           sel_uop;
  logic [FMT_ID_W-1:0] sel_id;
  logic [IMM_W-1:0]    imm_c;
  out_base_t           base_c;
  logic [REC_W-1:0]    rec_c;
  logic                push_c;
  logic                pop_c;

  logic [REC_W-1:0]    mem_q [2];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          count_q;

  // Lowest-index valid channel wins.
  always_comb begin
    sel_uop = '0;
    sel_id  = '0;
    for (int k = int'(NUM_FMT) - 1; k >= 0; k--) begin
      if (fmtValid_i[k]) begin
        sel_uop = fmtUop_i[k*UOP_W +: UOP_W];
        sel_id  = fmt_id_of(k);
      end
    end
  end

  imm_expand u_imm_expand (
    .imm_raw    (sel_uop.imm_raw),
    .imm_width  (sel_uop.imm_width),
    .imm_signed (sel_uop.imm_signed),
    .imm_shift  (sel_uop.imm_shift),
    .imm_enable (sel_uop.imm_en),
    .imm_c      (imm_c)
  );

  always_comb begin
    base_c         = '0;
    base_c.rt      = sel_uop.rt;
    base_c.ra      = sel_uop.ra;
    base_c.rb      = sel_uop.rb;
    base_c.rt_en   = sel_uop.rt_en;
    base_c.ra_en   = sel_uop.ra_en;
    base_c.rb_en   = sel_uop.rb_en;
    base_c.imm_en  = sel_uop.imm_en;
    base_c.bits    = sel_uop.bits;
    base_c.xopcode = sel_uop.xopcode;
    base_c.imm     = imm_c;
    base_c.fmt_id  = sel_id;
    rec_c          = {base_c, instructionAddress_i, opcode_i};
  end

  assign inReady_o = (count_q < 2'd2);
  assign valid_o   = (count_q != 2'd0);
  assign uop_o     = valid_o ? mem_q[rd_ptr_q] : '0;
  assign push_c    = (|fmtValid_i) && inReady_o && !flush_i;
  assign pop_c     = valid_o && ready_i;

  // Storage is left unreset; the head is qualified by count.
  always_ff @(posedge clock_i) begin
    if (push_c) mem_q[wr_ptr_q] <= rec_c;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_c) wr_ptr_q <= ~wr_ptr_q;
      if (pop_c)  rd_ptr_q <= ~rd_ptr_q;
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef DECODE_MUX_MULTIHOT_CHECK_EN
  logic multi_c;
  assign multi_c = ((fmtValid_i & (fmtValid_i - NUM_FMT'(1))) != '0) && inReady_o;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      multiHot_o      <= 1'b0;
      multiHotCount_o <= 8'd0;
    end else if (multi_c) begin
      multiHot_o <= 1'b1;
      if (multiHotCount_o != 8'hFF) multiHotCount_o <= multiHotCount_o + 8'd1;
    end
  end
`else
  assign multiHot_o      = 1'b0;
  assign multiHotCount_o = 8'd0;
`endif

endmodule

// File: tb/tb_decode_mux_stage.sv
// Table vectors, directed corner sequences and random traffic against a queue model.
module tb_decode_mux_stage;
  import decode_pkg::*;

  localparam int NF   = 6;
  localparam int AW   = 64;
  localparam int OW   = 6;
  localparam int OUTW = OUT_BASE_W + AW + OW;

  localparam logic [4:0] REF_ID [NF] = '{5'd3, 5'd4, 5'd5, 5'd15, 5'd9, 5'd19};

  logic               clock_i = 1'b0;
  logic               reset_i;
  logic               flush_i;
  logic [NF-1:0]      fmtValid_i;
  logic [NF*UOP_W-1:0] fmtUop_i;
  logic [AW-1:0]      instructionAddress_i;
  logic [OW-1:0]      opcode_i;
  logic               inReady_o;
  logic               valid_o;
  logic               ready_i;
  logic [OUTW-1:0]    uop_o;
  logic               multiHot_o;
  logic [7:0]         multiHotCount_o;

  decode_mux_stage dut (
    .clock_i              (clock_i),
    .reset_i              (reset_i),
    .flush_i              (flush_i),
    .fmtValid_i           (fmtValid_i),
    .fmtUop_i             (fmtUop_i),
    .instructionAddress_i (instructionAddress_i),
    .opcode_i             (opcode_i),
    .inReady_o            (inReady_o),
    .valid_o              (valid_o),
    .ready_i              (ready_i),
    .uop_o                (uop_o),
    .multiHot_o           (multiHot_o),
    .multiHotCount_o      (multiHotCount_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int errors = 0;
  logic [OUTW-1:0] q[$];
  bit   mh_exp = 1'b0;
  int   mh_cnt_exp = 0;
  chan_uop_t ch [NF];

  typedef struct {
    int          chn;
    logic [15:0] raw;
    logic [4:0]  w;
    logic        s;
    logic [5:0]  sh;
    logic        en;
    logic [63:0] imm;
    logic [4:0]  id;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [OUTW-1:0] act, input logic [OUTW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Immediate as a signed integer value, then scaled by 2**shift modulo 2**64.
  function automatic logic [63:0] model_imm(input chan_uop_t c);
    longint unsigned m;
    longint v;
    if (!c.imm_en) return 64'd0;
    m = longint'(c.imm_raw) % (longint'(1) << c.imm_width);
    v = longint'(m);
    if (c.imm_signed && (m >= (longint'(1) << (c.imm_width - 5'd1))))
      v = v - (longint'(1) << c.imm_width);
    return 64'(v) << c.imm_shift;
  endfunction

  function automatic logic [OUTW-1:0] expect_rec(input int k);
    out_base_t b;
    chan_uop_t c;
    c         = ch[k];
    b.rt      = c.rt;
    b.ra      = c.ra;
    b.rb      = c.rb;
    b.rt_en   = c.rt_en;
    b.ra_en   = c.ra_en;
    b.rb_en   = c.rb_en;
    b.imm_en  = c.imm_en;
    b.bits    = c.bits;
    b.xopcode = c.xopcode;
    b.imm     = model_imm(c);
    b.fmt_id  = REF_ID[k];
    return {b, instructionAddress_i, opcode_i};
  endfunction

  task automatic rand_ch();
    for (int k = 0; k < NF; k++) begin
      ch[k] = chan_uop_t'(UOP_W'({$urandom(), $urandom()}));
      ch[k].imm_width = 5'($urandom_range(1, 16));
    end
    instructionAddress_i = {$urandom(), $urandom()};
    opcode_i = 6'($urandom());
  endtask

  task automatic check_outputs();
    chk("valid_o", OUTW'(valid_o), OUTW'(q.size() != 0));
    chk("inReady_o", OUTW'(inReady_o), OUTW'(q.size() < 2));
    chk("uop_o", uop_o, (q.size() != 0) ? q[0] : '0);
    chk("multiHot_o", OUTW'(multiHot_o), OUTW'(mh_exp));
    chk("multiHotCount_o", OUTW'(multiHotCount_o), OUTW'(mh_cnt_exp));
  endtask

  // One clock: check state, drive inputs, advance the model, clock to next negedge.
  task automatic cycle(input logic [NF-1:0] v, input logic rdy, input logic fl);
    int sel;
    bit acc;
    bit pop;
    logic [OUTW-1:0] rec;
    check_outputs();
    fmtValid_i = v;
    ready_i    = rdy;
    flush_i    = fl;
    for (int k = 0; k < NF; k++) fmtUop_i[k*UOP_W +: UOP_W] = ch[k];
    sel = -1;
    for (int k = 0; k < NF; k++) begin
      if (v[k]) begin
        sel = k;
        break;
      end
    end
    acc = (sel >= 0) && (q.size() < 2) && !fl;
    pop = (q.size() != 0) && rdy;
`ifdef DECODE_MUX_MULTIHOT_CHECK_EN
    if (($countones(v) > 1) && (q.size() < 2)) begin
      mh_exp = 1'b1;
      if (mh_cnt_exp < 255) mh_cnt_exp++;
    end
`endif
    rec = '0;
    if (acc) rec = expect_rec(sel);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(rec);
    end
    @(posedge clock_i);
    @(negedge clock_i);
  endtask

  task automatic drain();
    repeat (3) cycle('0, 1'b1, 1'b0);
  endtask

  initial begin
    out_base_t b;
    logic [NF-1:0] v;

    tbl[0] = '{0, 16'h8000, 5'd16, 1'b1, 6'd16, 1'b1, 64'hFFFF_FFFF_8000_0000, 5'd3};
    tbl[1] = '{2, 16'h3FFF, 5'd14, 1'b1, 6'd2,  1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 5'd5};
    tbl[2] = '{2, 16'h3FFF, 5'd14, 1'b0, 6'd2,  1'b1, 64'h0000_0000_0000_FFFC, 5'd5};
    tbl[3] = '{5, 16'h1234, 5'd8,  1'b0, 6'd0,  1'b1, 64'h0000_0000_0000_0034, 5'd19};
    tbl[4] = '{3, 16'h0080, 5'd8,  1'b1, 6'd4,  1'b1, 64'hFFFF_FFFF_FFFF_F800, 5'd15};
    tbl[5] = '{4, 16'hFFFF, 5'd16, 1'b1, 6'd63, 1'b1, 64'h8000_0000_0000_0000, 5'd9};
    tbl[6] = '{1, 16'hFFFF, 5'd16, 1'b1, 6'd5,  1'b0, 64'h0000_0000_0000_0000, 5'd4};
    tbl[7] = '{0, 16'hC001, 5'd1,  1'b1, 6'd0,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3};
    tbl[8] = '{4, 16'h8765, 5'd12, 1'b1, 6'd0,  1'b1, 64'h0000_0000_0000_0765, 5'd9};

    reset_i = 1'b1;
    flush_i = 1'b0;
    ready_i = 1'b0;
    fmtValid_i = '0;
    fmtUop_i = '0;
    rand_ch();
    repeat (2) @(negedge clock_i);
    chk("reset_valid", OUTW'(valid_o), OUTW'(0));
    chk("reset_inready", OUTW'(inReady_o), OUTW'(1));
    chk("reset_uop", uop_o, '0);
    chk("reset_mh", OUTW'({multiHot_o, multiHotCount_o}), OUTW'(0));
    reset_i = 1'b0;

    // Multi-hot: ch1 and ch3 together, ch1 wins.
    rand_ch();
    cycle(6'b001010, 1'b1, 1'b0);
    b = out_base_t'(uop_o[OUTW-1 -: OUT_BASE_W]);
    chk("multihot_fmt_id", OUTW'(b.fmt_id), OUTW'(4));
`ifdef DECODE_MUX_MULTIHOT_CHECK_EN
    chk("multihot_flag", OUTW'(multiHot_o), OUTW'(1));
    chk("multihot_count", OUTW'(multiHotCount_o), OUTW'(1));
`else
    chk("multihot_flag", OUTW'(multiHot_o), OUTW'(0));
    chk("multihot_count", OUTW'(multiHotCount_o), OUTW'(0));
`endif
    drain();

    foreach (tbl[i]) begin
      rand_ch();
      ch[tbl[i].chn].imm_raw    = tbl[i].raw;
      ch[tbl[i].chn].imm_width  = tbl[i].w;
      ch[tbl[i].chn].imm_signed = tbl[i].s;
      ch[tbl[i].chn].imm_shift  = tbl[i].sh;
      ch[tbl[i].chn].imm_en     = tbl[i].en;
      cycle(NF'(1) << tbl[i].chn, 1'b1, 1'b0);
      b = out_base_t'(uop_o[OUTW-1 -: OUT_BASE_W]);
      chk($sformatf("tbl%0d_valid", i), OUTW'(valid_o), OUTW'(1));
      chk($sformatf("tbl%0d_imm", i), OUTW'(b.imm), OUTW'(tbl[i].imm));
      chk($sformatf("tbl%0d_fmt_id", i), OUTW'(b.fmt_id), OUTW'(tbl[i].id));
    end
    drain();

    // Backpressure: three accepts with ready low, only two stored.
    for (int i = 0; i < 3; i++) begin
      rand_ch();
      cycle(6'b000100, 1'b0, 1'b0);
      if (i == 1) chk("bp_inready_full", OUTW'(inReady_o), OUTW'(0));
    end
    chk("bp_valid_held", OUTW'(valid_o), OUTW'(1));
    drain();

    // Full plus pop: inReady stays low in the pop cycle.
    rand_ch();
    cycle(6'b000001, 1'b0, 1'b0);
    cycle(6'b000001, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0);
    chk("pop_inready_back", OUTW'(inReady_o), OUTW'(1));
    drain();

    // Flush with buffer full and a valid input.
    rand_ch();
    cycle(6'b010000, 1'b0, 1'b0);
    rand_ch();
    cycle(6'b100000, 1'b0, 1'b0);
    rand_ch();
    instructionAddress_i = 64'hDEAD_BEEF_0000_F1F1;
    cycle(6'b000001, 1'b0, 1'b1);
    chk("flush_valid", OUTW'(valid_o), OUTW'(0));
    chk("flush_inready", OUTW'(inReady_o), OUTW'(1));
    drain();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      rand_ch();
      case ($urandom_range(0, 3))
        0:       v = '0;
        1:       v = NF'($urandom());
        default: v = NF'(1) << $urandom_range(0, NF - 1);
      endcase
      cycle(v, ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
    end
    drain();

    // Asynchronous reset in the middle of a drain.
    rand_ch();
    cycle(6'b000010, 1'b0, 1'b0);
    cycle(6'b001000, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0);
    #1 reset_i = 1'b1;
    #1;
    chk("areset_valid", OUTW'(valid_o), OUTW'(0));
    chk("areset_inready", OUTW'(inReady_o), OUTW'(1));
    chk("areset_uop", uop_o, '0);
    chk("areset_mh", OUTW'({multiHot_o, multiHotCount_o}), OUTW'(0));
    q.delete();
    mh_exp = 1'b0;
    mh_cnt_exp = 0;
    @(negedge clock_i);
    reset_i = 1'b0;
    rand_ch();
    cycle(6'b000100, 1'b1, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
